// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: byte/half/word loads and stores with wait states
// IDLE/BUSY/DONE handshake; the access commits on the edge that raises ready.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        dmem_w_i,
  input  logic        dmem_r_i,
  input  logic [1:0]  store_format_signal_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  localparam logic [1:0] FMT_WORD = 2'b00;
  localparam logic [1:0] FMT_HALF = 2'b01;
  localparam logic [1:0] FMT_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  fmt_q, fmt_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_q [DEPTH];

  logic          req;
  logic          accept;
  logic          commit;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [1:0]    acc_fmt;
  logic          acc_wr;
  logic          acc_err;
  logic [AW-1:0] word_idx;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data;
  logic          mem_we;
  logic [31:0]   word_rd;
  logic [15:0]   half_rd;
  logic [7:0]    byte_rd;
  logic [31:0]   rd_aligned;

  assign req    = dmem_w_i | dmem_r_i;
  assign accept = (state_q == IDLE) && req;
  assign commit = (accept && (WAIT_CYCLES == 0)) ||
                  ((state_q == BUSY) && (cnt_q == 4'd1));

  // With no wait states the access uses the live request; otherwise the latched copy.
  assign acc_addr  = (state_q == IDLE) ? addr_i                : addr_q;
  assign acc_wdata = (state_q == IDLE) ? wdata_i               : wdata_q;
  assign acc_fmt   = (state_q == IDLE) ? store_format_signal_i : fmt_q;
  assign acc_wr    = (state_q == IDLE) ? dmem_w_i              : wr_q;

  assign word_idx = acc_addr[AW+1:2];

  always_comb begin
    acc_err = |acc_addr[31:AW+2];
    case (acc_fmt)
      FMT_WORD: if (acc_addr[1:0] != 2'b00) acc_err = 1'b1;
      FMT_HALF: if (acc_addr[0]) acc_err = 1'b1;
      FMT_BYTE: ;
      default:  acc_err = 1'b1;
    endcase
  end

  always_comb begin
    lane_en   = 4'b0000;
    lane_data = 32'h0;
    case (acc_fmt)
      FMT_WORD: begin
        lane_en   = 4'b1111;
        lane_data = acc_wdata;
      end
      FMT_HALF: begin
        lane_en   = acc_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{acc_wdata[15:0]}};
      end
      FMT_BYTE: begin
        lane_en   = 4'b0001 << acc_addr[1:0];
        lane_data = {4{acc_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  assign mem_we = rst_ni && commit && acc_wr && !acc_err;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) mem_q[word_idx][8*k +: 8] <= lane_data[8*k +: 8];
      end
    end
  end

  assign word_rd = mem_q[word_idx];
  assign half_rd = acc_addr[1] ? word_rd[31:16] : word_rd[15:0];

  always_comb begin
    case (acc_addr[1:0])
      2'd0:    byte_rd = word_rd[7:0];
      2'd1:    byte_rd = word_rd[15:8];
      2'd2:    byte_rd = word_rd[23:16];
      default: byte_rd = word_rd[31:24];
    endcase
  end

  always_comb begin
    case (acc_fmt)
      FMT_WORD: rd_aligned = word_rd;
      FMT_HALF: rd_aligned = {16'h0, half_rd};
      FMT_BYTE: rd_aligned = {24'h0, byte_rd};
      default:  rd_aligned = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fmt_d   = fmt_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          fmt_d   = store_format_signal_i;
          wr_d    = dmem_w_i;
          if (WAIT_CYCLES == 0) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = WAIT_LD;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Writes leave rdata alone so the last load stays visible to the core.
    if (commit) begin
      err_d = acc_err;
      if (!acc_wr) rdata_d = acc_err ? 32'h0 : rd_aligned;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      fmt_q   <= 2'b00;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fmt_q   <= fmt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign ready_o = (state_q == DONE);
  assign err_o   = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - bench for dmem_responder, zero-wait and three-wait instances side by side
// Both instances share the request inputs; a byte-addressed model predicts every cycle.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        dw;
  logic        dr;
  logic [1:0]  fmt;

  logic [31:0] rdata0, rdata3;
  logic        ready0, ready3, err0, err3;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic rdy0_snap, err0_snap, rdy3_snap;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .wdata_i(wdata),
    .dmem_w_i(dw), .dmem_r_i(dr), .store_format_signal_i(fmt),
    .rdata_o(rdata0), .ready_o(ready0), .err_o(err0)
  );

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .wdata_i(wdata),
    .dmem_w_i(dw), .dmem_r_i(dr), .store_format_signal_i(fmt),
    .rdata_o(rdata3), .ready_o(ready3), .err_o(err3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state, index 0 = zero-wait instance, 1 = three-wait instance.
  logic [7:0]  mmem [2][4096];
  bit          pend [2];
  int          commit_e [2];
  int          free_e [2];
  logic        pw [2];
  logic [31:0] pa [2];
  logic [31:0] pd [2];
  logic [1:0]  pf [2];
  logic        exp_rdy [2];
  logic        exp_err [2];
  logic [31:0] exp_rd [2];

  function automatic int waits(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic model_access(input int k);
    logic [11:0] a;
    bit          e;
    a = pa[k][11:0];
    e = (pa[k] >= 32'd4096) || (pf[k] == 2'd3) ||
        (pf[k] == 2'd1 && pa[k][0]) || (pf[k] == 2'd0 && pa[k][1:0] != 2'd0);
    if (pw[k]) begin
      if (!e) begin
        if (pf[k] == 2'd0) begin
          for (int i = 0; i < 4; i++) mmem[k][a + 12'(i)] = pd[k][8*i +: 8];
        end else if (pf[k] == 2'd1) begin
          mmem[k][a]         = pd[k][7:0];
          mmem[k][a + 12'd1] = pd[k][15:8];
        end else begin
          mmem[k][a] = pd[k][7:0];
        end
      end
    end else if (e) begin
      exp_rd[k] = 32'h0;
    end else if (pf[k] == 2'd0) begin
      exp_rd[k] = {mmem[k][a + 12'd3], mmem[k][a + 12'd2], mmem[k][a + 12'd1], mmem[k][a]};
    end else if (pf[k] == 2'd1) begin
      exp_rd[k] = {16'h0, mmem[k][a + 12'd1], mmem[k][a]};
    end else begin
      exp_rd[k] = {24'h0, mmem[k][a]};
    end
    exp_rdy[k] = 1'b1;
    exp_err[k] = e;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0; free_e[k] = 0; commit_e[k] = 0;
      exp_rdy[k] = 0; exp_err[k] = 0; exp_rd[k] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        exp_rdy[k] = 1'b0;
        exp_err[k] = 1'b0;
        if (!rst_n) begin
          pend[k]   = 0;
          free_e[k] = 0;
          exp_rd[k] = 32'h0;
        end else begin
          if (!pend[k] && cyc >= free_e[k] && (dw || dr)) begin
            pend[k]     = 1;
            pw[k]       = dw;
            pa[k]       = addr;
            pd[k]       = wdata;
            pf[k]       = fmt;
            commit_e[k] = cyc + waits(k);
            free_e[k]   = cyc + waits(k) + 2;
          end
          if (pend[k] && cyc == commit_e[k]) begin
            model_access(k);
            pend[k] = 0;
          end
        end
      end
      #2;
      chk("cyc_ready0", {31'h0, ready0}, {31'h0, exp_rdy[0]});
      chk("cyc_err0",   {31'h0, err0},   {31'h0, exp_err[0]});
      chk("cyc_rdata0", rdata0, exp_rd[0]);
      chk("cyc_ready3", {31'h0, ready3}, {31'h0, exp_rdy[1]});
      chk("cyc_err3",   {31'h0, err3},   {31'h0, exp_err[1]});
      chk("cyc_rdata3", rdata3, exp_rd[1]);
    end
  end

  // One-cycle request; returns at the negedge after the three-wait instance raised ready.
  task automatic req(input logic w, input logic r, input logic [1:0] f,
                     input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    dw = w; dr = r; fmt = f; addr = a; wdata = d;
    @(negedge clk);
    dw = 1'b0; dr = 1'b0;
    rdy0_snap = ready0; err0_snap = err0; rdy3_snap = ready3;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; dw = 1'b0; dr = 1'b0; fmt = 2'b00; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_ready0", {31'h0, ready0}, 32'h0);
    chk("rst_err3",   {31'h0, err3},   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    req(1, 0, 2'b00, 32'h20, 32'h0);
    req(1, 0, 2'b00, 32'h24, 32'hCAFEF00D);

    req(1, 0, 2'b00, 32'h10, 32'h12345678);
    chk("t1_wr_ready0_next", {31'h0, rdy0_snap}, 32'h1);
    chk("t1_wr_ready3_early", {31'h0, rdy3_snap}, 32'h0);
    chk("t1_wr_ready3", {31'h0, ready3}, 32'h1);
    chk("t1_wr_err3", {31'h0, err3}, 32'h0);
    req(0, 1, 2'b00, 32'h10, 32'h0);
    chk("t1_rd_rdata0", rdata0, 32'h12345678);
    chk("t1_rd_rdata3", rdata3, 32'h12345678);

    req(1, 0, 2'b10, 32'h11, 32'h000000AB);
    req(0, 1, 2'b00, 32'h10, 32'h0);
    chk("t2_byte_store", rdata3, 32'h1234AB78);
    req(1, 0, 2'b01, 32'h12, 32'h0000BEEF);
    req(0, 1, 2'b00, 32'h10, 32'h0);
    chk("t2_half_store", rdata3, 32'hBEEFAB78);
    req(0, 1, 2'b10, 32'h13, 32'h0);
    chk("t2_byte_load0", rdata0, 32'h000000BE);
    chk("t2_byte_load3", rdata3, 32'h000000BE);
    req(0, 1, 2'b01, 32'h10, 32'h0);
    chk("t2_half_load", rdata3, 32'h0000AB78);

    req(1, 0, 2'b01, 32'h11, 32'h00005555);
    chk("t3_mis_half_err0", {31'h0, err0_snap}, 32'h1);
    chk("t3_mis_half_rdy0", {31'h0, rdy0_snap}, 32'h1);
    chk("t3_mis_half_err3", {31'h0, err3}, 32'h1);
    req(0, 1, 2'b00, 32'h4002, 32'h0);
    chk("t3_oor_err3", {31'h0, err3}, 32'h1);
    chk("t3_oor_rdata3", rdata3, 32'h0);
    req(1, 0, 2'b11, 32'h10, 32'h0);
    chk("t3_fmt11_err3", {31'h0, err3}, 32'h1);
    req(0, 1, 2'b00, 32'h10, 32'h0);
    chk("t3_word_intact", rdata3, 32'hBEEFAB78);

    // Three-wait read of 0x10 with competing requests during BUSY and DONE.
    @(negedge clk);
    dr = 1'b1; fmt = 2'b00; addr = 32'h10;
    @(negedge clk);
    dr = 1'b0;
    @(negedge clk);
    dr = 1'b1; addr = 32'h24;
    @(negedge clk);
    dr = 1'b0;
    chk("t4_ready3_busy", {31'h0, ready3}, 32'h0);
    @(negedge clk);
    dr = 1'b1;
    chk("t4_ready3_done", {31'h0, ready3}, 32'h1);
    chk("t4_rdata3_first_req", rdata3, 32'hBEEFAB78);
    @(negedge clk);
    dr = 1'b0;
    chk("t4_ready3_single", {31'h0, ready3}, 32'h0);
    repeat (3) @(negedge clk);
    chk("t4_rdata0_late", rdata0, 32'hCAFEF00D);
    chk("t4_rdata3_ignored", rdata3, 32'hBEEFAB78);

    req(1, 1, 2'b00, 32'h24, 32'h01020304);
    chk("t4_rw_rdata_held", rdata3, 32'hBEEFAB78);
    req(0, 1, 2'b00, 32'h24, 32'h0);
    chk("t4_rw_was_write", rdata3, 32'h01020304);

    @(negedge clk);
    dw = 1'b1; fmt = 2'b00; addr = 32'h20; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    dw = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready3", {31'h0, ready3}, 32'h0);
    chk("t5_rst_rdata3", rdata3, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req(0, 1, 2'b00, 32'h20, 32'h0);
    chk("t5_aborted_write3", rdata3, 32'h0);
    chk("t5_committed_write0", rdata0, 32'hFFFFFFFF);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the multicycle CPU's load/store port: it takes the byte address, store data, read/write strobes and 2-bit access format that the core drives, and holds the data-memory array. It produces a registered, lane-aligned read word for the core's MDR path and commits byte, halfword and word stores with the correct byte lanes. Requests run through a small IDLE/BUSY/DONE state machine with programmable wait cycles and a one-cycle `ready` pulse, so slower memories can later sit behind the same port.

## Interface
- `DEPTH`, default 1024: number of 32-bit words in the array; power of two.
- `WAIT_CYCLES`, default 0: extra BUSY cycles inserted before each access commits; range 0–15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `addr` in 32: byte address. The word index is `addr[log2(DEPTH)+1:2]`.
- `wdata` in 32: store data. The byte or halfword is taken right-aligned, from bits [7:0] or [15:0].
- `dmem_w` in 1: write request strobe.
- `dmem_r` in 1: read request strobe.
- `store_format_signal` in 2: access format, used for both loads and stores. 00 = word, 01 = halfword, 10 = byte, 11 = reserved.
- `rdata` out 32: registered read result, right-aligned.
- `ready` out 1: single-cycle pulse marking completion of an access.
- `err` out 1: single-cycle pulse, coincident with `ready`, marking a rejected access.

## Operation
- **States:** IDLE, BUSY, DONE.
- **Request sampling:** requests are sampled only in IDLE. `addr`, `wdata` and `store_format_signal` are latched at the accepting edge; later changes are ignored.
- **Read/write priority:** `dmem_w` and `dmem_r` high together are treated as a write only.
- **IDLE with a request:**
  - `WAIT_CYCLES` = 0: the access is performed at the accepting edge and the state goes to DONE.
  - Otherwise: the state goes to BUSY with the counter loaded to `WAIT_CYCLES`.
- **BUSY:** the counter decrements each cycle. When the counter is 1, the access is performed at that edge and the state goes to DONE.
- **DONE:** `ready` = 1 for this one cycle, then the state returns to IDLE unconditionally. A request present during DONE is not accepted until IDLE.
- **Error cases.** Any of the following makes the access an error: `err` = 1 in DONE, no array write, `rdata` forced to 0 for reads.
  - Address out of range, i.e. any bit of `addr[31:log2(DEPTH)+2]` nonzero.
  - Format 11.
  - Halfword with `addr[0]` = 1.
  - Word with `addr[1:0]` ≠ 0.
- **Store lanes** (lane k = bits [8k+7:8k]; only the listed lanes change):
  - Word: all four lanes.
  - Halfword: lanes {2·addr[1], 2·addr[1]+1} receive `wdata[15:0]`.
  - Byte: lane `addr[1:0]` receives `wdata[7:0]`.
- **Load alignment.** `rdata` is loaded at the commit edge:
  - Word: the whole word.
  - Halfword: `{16'b0, word >> 16·addr[1]}` in the low 16 bits.
  - Byte: `{24'b0, word >> 8·addr[1:0]}` in the low 8 bits.
  - The core's extenders perform sign or zero extension.
- **`rdata` hold:** `rdata` is unchanged by writes and holds until the next read commits.
- **Array contents:** not cleared by reset and undefined until written. Implement as a register array with per-lane write enables.

## Timing
- **Reset values:** state IDLE, counter 0, `rdata` = 0, `ready` = 0, `err` = 0. Reset is asserted asynchronously and released on a clock edge.
- **Latency:** request accepted at edge E0. `ready` is high during the cycle following edge E0+`WAIT_CYCLES`.
  - `WAIT_CYCLES` = 0: latency 1 cycle; back-to-back throughput is one access per 2 cycles.
  - `WAIT_CYCLES` = N: latency N+1 cycles; throughput one access per N+2 cycles.
- **Read data:** `rdata` is valid in the same cycle `ready` is high, and remains valid afterwards.
- **Write visibility:** a write commits at the same edge that raises `ready`. A read accepted on any later IDLE cycle returns the new data.
- **Reset mid-access:** reset during BUSY aborts the access. No write is committed, no `ready` pulse is produced, and `rdata` = 0.

## Test plan
1. **Word write then read.** `WAIT_CYCLES` = 0. Write word 0x12345678 to addr 0x10, then read addr 0x10. Required: `ready` one cycle after each accept, `rdata` = 0x12345678, `err` = 0.
2. **Byte and halfword stores and loads.**
   - Store byte 0xAB at 0x11 into word 0x12345678 → word becomes 0x1234AB78.
   - Store halfword 0xBEEF at 0x12 → word becomes 0xBEEFAB78.
   - Byte read at 0x13 → `rdata` = 0x000000BE.
   - Halfword read at 0x10 → `rdata` = 0x0000AB78.
3. **Error cases.**
   - Halfword write at 0x11: `err` and `ready` pulse together, word unchanged.
   - Word read at 0x4002 with DEPTH = 1024: `err` = 1, `rdata` = 0.
   - Format 11 write: `err` = 1, no write.
4. **Wait cycles.** `WAIT_CYCLES` = 3. Read accepted at E0 → `ready` high only in the cycle after E3. Requests toggled during BUSY/DONE are ignored. `dmem_r` and `dmem_w` high together → write performed, `rdata` unchanged.
5. **Reset mid-access.** `WAIT_CYCLES` = 3. Pull `rst` low during BUSY of a write of 0xFFFFFFFF to 0x20 that previously held 0x0. Required: immediate `ready` = 0 and `rdata` = 0; after release a read of 0x20 returns 0x00000000.
